// File: rtl/dff_bank_arbiter_pkg.sv
// Shared definitions for the dff_bank_arbiter slice: FSM state codes,
// the owner index width, and the round-robin pointer advance helper.
package dff_bank_arbiter_pkg;

  localparam int OWNER_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Next round-robin pointer: one past the winner, wrapping NREQ-1 -> 0.
  function automatic logic [OWNER_W-1:0] rr_next(input logic [OWNER_W-1:0] idx,
                                                 input int nreq);
    if (int'(idx) >= nreq - 1) return '0;
    else return idx + 1'b1;
  endfunction

endpackage

// File: rtl/dff_bank_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Searches req starting at ptr,
// then ptr+1, ... modulo NREQ, and returns the first set index plus a flag
// saying whether any request was present.
module rr_pick
  import dff_bank_arbiter_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]    req_i,
  input  logic [OWNER_W-1:0] ptr_i,
  output logic [OWNER_W-1:0] idx_o,
  output logic               any_o
);

  // Walk offsets from highest to lowest so the smallest offset from ptr wins.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      int j;
      j = int'(ptr_i) + i;
      if (j >= NREQ) j = j - NREQ;
      if (req_i[j]) begin
        idx_o = OWNER_W'(j);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter: shares one WIDTH-bit storage register among NREQ
// requesters using a round-robin req/gnt/ack handshake (IDLE -> GRANT -> DONE).
// Optional feature macro: DFF_ARB_PARITY_EN adds the ans_par output, the even
// parity of the stored word, registered alongside ans.
//
// Handshake: a requester holds req high (and its data_in slice stable) until it
// sees ack. gnt is a one-hot registered grant lasting one cycle; on the next
// edge, if the granted req is still high, its word is captured into ans and ack
// pulses for one cycle. Dropping req while granted aborts without a write.
module dff_bank_arbiter
  import dff_bank_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   data_in,
  output logic [NREQ-1:0]         gnt,
  output logic                    ack,
  output logic [OWNER_W-1:0]      owner,
  output logic [1:0]              dbg_state,
  output logic [WIDTH-1:0]        ans
`ifdef DFF_ARB_PARITY_EN
  ,
  output logic                    ans_par
`endif
);

  state_e               state_q;
  logic [NREQ-1:0]      gnt_q;
  logic                 ack_q;
  logic [OWNER_W-1:0]   owner_q;
  logic [OWNER_W-1:0]   ptr_q;
  logic [OWNER_W-1:0]   idx_q;
  logic [WIDTH-1:0]     ans_q;
  logic [WIDTH-1:0]     ans_d;
  logic [NREQ-1:0]      gnt_d;
  logic [OWNER_W-1:0]   pick_idx;
  logic                 pick_any;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Candidate grant vector and the word the granted requester presents.
  assign gnt_d = NREQ'(1) << pick_idx;
  assign ans_d = data_in[idx_q*WIDTH +: WIDTH];

`ifdef DFF_ARB_PARITY_EN
  logic ans_par_q;

  // Parity flop is written on the same edge as ans so it always matches ^ans.
  always_ff @(posedge clk) begin
    if (rst) ans_par_q <= 1'b0;
    else if (state_q == ST_GRANT && req[idx_q]) ans_par_q <= ^ans_d;
  end

  assign ans_par = ans_par_q;
`endif

  // Arbitration FSM with registered grant, ack, owner, pointer and storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ack_q   <= 1'b0;
      owner_q <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      ans_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_q <= 1'b0;
          if (pick_any) begin
            gnt_q   <= gnt_d;
            idx_q   <= pick_idx;
            state_q <= ST_GRANT;
          end else begin
            gnt_q <= '0;
          end
        end
        ST_GRANT: begin
          gnt_q <= '0;
          if (req[idx_q]) begin
            ans_q   <= ans_d;
            owner_q <= idx_q;
            ack_q   <= 1'b1;
            ptr_q   <= rr_next(idx_q, NREQ);
            state_q <= ST_DONE;
          end else begin
            // Withdrawn request: no write, pointer stays so it keeps priority.
            state_q <= ST_IDLE;
          end
        end
        ST_DONE: begin
          ack_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          gnt_q   <= '0;
          ack_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign ack       = ack_q;
  assign owner     = owner_q;
  assign ans       = ans_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Testbench for dff_bank_arbiter: directed scenarios plus randomized writes,
// checked against a transaction-level model (winner search, stored word,
// owner, pointer). Define DFF_ARB_PARITY_EN to also check ans_par.
module tb_dff_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data_in;
  logic [NREQ-1:0]       gnt;
  logic                  ack;
  logic [2:0]            owner;
  logic [1:0]            dbg_state;
  logic [WIDTH-1:0]      ans;
`ifdef DFF_ARB_PARITY_EN
  logic                  ans_par;
`endif

  int n_compared;
  int n_mismatched;

  // Transaction-level model state.
  int               m_ptr;
  logic [WIDTH-1:0] m_ans;
  int               m_owner;
  logic [WIDTH-1:0] exp_q[$];

  dff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data_in   (data_in),
    .gnt       (gnt),
    .ack       (ack),
    .owner     (owner),
    .dbg_state (dbg_state),
    .ans       (ans)
`ifdef DFF_ARB_PARITY_EN
    ,
    .ans_par   (ans_par)
`endif
  );

  // Clock and run-time guard.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // First requester at or after p (mod NREQ) whose bit is set.
  function automatic int model_pick(input logic [NREQ-1:0] mask, input int p);
    for (int i = 0; i < NREQ; i++) begin
      int j;
      j = (p + i) % NREQ;
      if (mask[j]) return j;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string name);
    n_compared++;
    if (gnt !== '0) begin
      n_mismatched++;
      $display("FAIL %s gnt: got %b want 0", name, gnt);
    end
    n_compared++;
    if (ack !== 1'b0) begin
      n_mismatched++;
      $display("FAIL %s ack: got %b want 0", name, ack);
    end
    n_compared++;
    if (ans !== m_ans) begin
      n_mismatched++;
      $display("FAIL %s ans: got %h want %h", name, ans, m_ans);
    end
`ifdef DFF_ARB_PARITY_EN
    n_compared++;
    if (ans_par !== ^m_ans) begin
      n_mismatched++;
      $display("FAIL %s ans_par: got %b want %b", name, ans_par, ^m_ans);
    end
`endif
  endtask

  // One full transaction from IDLE with req=0; ends with DUT back in IDLE.
  task automatic do_write(input logic [NREQ-1:0] mask,
                          input logic [NREQ*WIDTH-1:0] words,
                          input bit withdraw,
                          input string name);
    int w;
    logic [NREQ-1:0] exp_gnt;
    @(negedge clk);
    req     = mask;
    data_in = words;
    w = model_pick(mask, m_ptr);
    exp_gnt = '0;
    exp_gnt[w] = 1'b1;
    tick();
    n_compared++;
    if (gnt !== exp_gnt) begin
      n_mismatched++;
      $display("FAIL %s grant: got %b want %b", name, gnt, exp_gnt);
    end
    n_compared++;
    if (ack !== 1'b0) begin
      n_mismatched++;
      $display("FAIL %s ack_during_gnt: got %b want 0", name, ack);
    end
    if (withdraw) begin
      @(negedge clk);
      req = '0;
      tick();
      check_idle_outputs({name, "_withdraw"});
    end else begin
      exp_q.push_back(words[w*WIDTH +: WIDTH]);
      tick();
      m_ans   = exp_q.pop_front();
      m_owner = w;
      m_ptr   = (w + 1) % NREQ;
      n_compared++;
      if (ack !== 1'b1) begin
        n_mismatched++;
        $display("FAIL %s ack: got %b want 1", name, ack);
      end
      n_compared++;
      if (gnt !== '0) begin
        n_mismatched++;
        $display("FAIL %s gnt_with_ack: got %b want 0", name, gnt);
      end
      n_compared++;
      if (ans !== m_ans) begin
        n_mismatched++;
        $display("FAIL %s ans: got %h want %h", name, ans, m_ans);
      end
      n_compared++;
      if (int'(owner) !== m_owner) begin
        n_mismatched++;
        $display("FAIL %s owner: got %0d want %0d", name, owner, m_owner);
      end
`ifdef DFF_ARB_PARITY_EN
      n_compared++;
      if (ans_par !== ^m_ans) begin
        n_mismatched++;
        $display("FAIL %s ans_par: got %b want %b", name, ans_par, ^m_ans);
      end
`endif
      @(negedge clk);
      req = '0;
      tick();
      check_idle_outputs({name, "_done"});
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    m_ans = '0;
    m_owner = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 4'b1111;
    data_in = {8'h44, 8'h33, 8'h22, 8'h11};
    m_ans = '0;
    for (int c = 0; c < 2; c++) begin
      tick();
      check_idle_outputs("reset");
      n_compared++;
      if (owner !== 3'd0) begin
        n_mismatched++;
        $display("FAIL reset owner: got %0d want 0", owner);
      end
    end
    @(negedge clk);
    req = '0;
    rst = 1'b0;
    m_ptr = 0;
    m_owner = 0;
    tick();
    check_idle_outputs("post_reset");
  endtask

  task automatic test_single();
    logic [NREQ*WIDTH-1:0] words;
    words = {8'h00, 8'hA5, 8'h00, 8'h00};
    do_write(4'b0100, words, 1'b0, "single");
    tick();
    check_idle_outputs("single_hold");
  endtask

  task automatic test_fairness();
    int order[5];
    logic [NREQ-1:0] exp_gnt;
    logic [WIDTH-1:0] w_exp;
    order = '{0, 1, 2, 3, 0};
    apply_reset();
    @(negedge clk);
    req = 4'b1111;
    data_in = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    for (int k = 0; k < 5; k++) begin
      exp_gnt = '0;
      exp_gnt[order[k]] = 1'b1;
      tick();
      n_compared++;
      if (gnt !== exp_gnt) begin
        n_mismatched++;
        $display("FAIL fair_grant%0d: got %b want %b", k, gnt, exp_gnt);
      end
      tick();
      w_exp = data_in[order[k]*WIDTH +: WIDTH];
      n_compared++;
      if (ack !== 1'b1 || ans !== w_exp || int'(owner) !== order[k]) begin
        n_mismatched++;
        $display("FAIL fair_write%0d: got ack=%b ans=%h owner=%0d want ack=1 ans=%h owner=%0d",
                 k, ack, ans, owner, w_exp, order[k]);
      end
      tick();
      n_compared++;
      if (ack !== 1'b0 || gnt !== '0) begin
        n_mismatched++;
        $display("FAIL fair_done%0d: got ack=%b gnt=%b want ack=0 gnt=0", k, ack, gnt);
      end
      m_ans = w_exp;
      m_owner = order[k];
      m_ptr = (order[k] + 1) % NREQ;
    end
    @(negedge clk);
    req = '0;
    tick();
    tick();
    check_idle_outputs("fair_end");
  endtask

  task automatic test_withdrawal();
    do_write(4'b0001, {8'h00, 8'h00, 8'h00, 8'h5C}, 1'b0, "wd_pre");
    do_write(4'b0010, {8'h00, 8'h00, 8'hEE, 8'h00}, 1'b1, "wd_drop");
    do_write(4'b0011, {8'h00, 8'h00, 8'h7E, 8'h11}, 1'b0, "wd_again");
    n_compared++;
    if (owner !== 3'd1) begin
      n_mismatched++;
      $display("FAIL wd_owner: got %0d want 1", owner);
    end
  endtask

  task automatic test_reset_mid();
    do_write(4'b1000, {8'h9B, 8'h00, 8'h00, 8'h00}, 1'b0, "mid_pre");
    @(negedge clk);
    req = 4'b0010;
    data_in = {8'h00, 8'h00, 8'h66, 8'h00};
    tick();
    n_compared++;
    if (gnt !== 4'b0010) begin
      n_mismatched++;
      $display("FAIL mid_grant: got %b want 0010", gnt);
    end
    @(negedge clk);
    rst = 1'b1;
    m_ans = '0;
    m_ptr = 0;
    m_owner = 0;
    tick();
    check_idle_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_idle_outputs("mid_after");
    end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] mask;
    logic [NREQ*WIDTH-1:0] words;
    bit wd;
    for (int t = 0; t < 40; t++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) words[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      wd = ($urandom_range(0, 4) == 0);
      do_write(mask, words, wd, $sformatf("rand%0d", t));
      if ($urandom_range(0, 1) == 1) begin
        tick();
        check_idle_outputs($sformatf("rand%0d_gap", t));
      end
    end
  endtask

`ifdef DFF_ARB_PARITY_EN
  task automatic test_parity();
    do_write(4'b0001, {8'h00, 8'h00, 8'h00, 8'h07}, 1'b0, "par07");
    n_compared++;
    if (ans_par !== 1'b1) begin
      n_mismatched++;
      $display("FAIL par07: got %b want 1", ans_par);
    end
    do_write(4'b0010, {8'h00, 8'h00, 8'h03, 8'h00}, 1'b0, "par03");
    n_compared++;
    if (ans_par !== 1'b0) begin
      n_mismatched++;
      $display("FAIL par03: got %b want 0", ans_par);
    end
  endtask
`endif

  initial begin
    n_compared = 0;
    n_mismatched = 0;
    rst = 1'b0;
    req = '0;
    data_in = '0;
    m_ptr = 0;
    m_ans = '0;
    m_owner = 0;
    test_reset();
    test_single();
    test_fairness();
    test_withdrawal();
    test_reset_mid();
    test_random();
`ifdef DFF_ARB_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
